// File: rtl/sortn_sa.sv
// CBM bus slave holding N entries of W bits.
// The entries are sorted in place by odd-even transposition, one pass per clock.
module sortn_sa #(
   parameter int W  = 8,
   parameter int N  = 8,
   parameter int AW = 32
) (
   input  logic          bus1_HCLK,
   input  logic          bus1_HRESET,
   input  logic          sortn_SA_bus1_CBM_read_req,
   input  logic          sortn_SA_bus1_CBM_write_req,
   input  logic [AW-1:0] sortn_SA_bus1_CBM_addr,
   input  logic [2:0]    sortn_SA_bus1_CBM_size,
   input  logic [31:0]   sortn_SA_bus1_CBM_write_data,
   output logic [31:0]   sortn_SA_bus1_CBM_read_data,
   output logic          sortn_SA_bus1_CBM_busy,
   output logic          sortn_SA_bus1_CBM_error,
   output logic [W-1:0]  out_sorted,
   output logic          sort_done
);

   localparam int IW = $clog2(N);
   localparam int PW = $clog2(N);

   typedef enum logic {IDLE, SORT} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    entries [N];
   logic [W-1:0]    nxt     [N];
   logic [PW-1:0]   pass_q;
   logic            mode_q;
   logic            done_q;

   logic            rd_req, wr_req, req;
   logic [AW-1:0]   addr;
   logic [31:0]     wr_data;
   logic            is_entry, is_ctrl, is_status, mapped;
   logic            err, bsy, rd_acc, wr_acc;
   logic [IW-1:0]   idx;
   logic [31:0]     rd_val;
   logic            last_pass;
   logic            unused_wr_bits;

   assign rd_req  = sortn_SA_bus1_CBM_read_req;
   assign wr_req  = sortn_SA_bus1_CBM_write_req;
   assign req     = rd_req | wr_req;
   assign addr    = sortn_SA_bus1_CBM_addr;
   assign wr_data = sortn_SA_bus1_CBM_write_data;
   assign unused_wr_bits = ^wr_data;

   // Only word-aligned addresses are mapped.
   assign is_entry  = (addr[1:0] == 2'b00) && (addr < AW'(4 * N));
   assign is_ctrl   = (addr == AW'(4 * N));
   assign is_status = (addr == AW'(4 * N + 4));
   assign mapped    = is_entry | is_ctrl | is_status;
   assign idx       = addr[2 +: IW];

   assign err = req & ((rd_req & wr_req) | ~mapped |
                       (sortn_SA_bus1_CBM_size > 3'd2) | (wr_req & is_status));
   assign bsy = req & ~err & (state_q == SORT) & ~(rd_req & is_status);

   assign rd_acc = rd_req & ~err & ~bsy;
   assign wr_acc = wr_req & ~err & ~bsy;

   assign sortn_SA_bus1_CBM_error = err;
   assign sortn_SA_bus1_CBM_busy  = bsy;

   assign last_pass = (pass_q == PW'(N - 1));

   always_comb begin
      rd_val = '0;
      if (is_entry)       rd_val[W-1:0] = entries[idx];
      else if (is_ctrl)   rd_val        = {30'b0, mode_q, 1'b0};
      else if (is_status) rd_val        = {30'b0, done_q, state_q == SORT};
   end

   // Even passes pair (0,1),(2,3)...; odd passes pair (1,2),(3,4)... Pairs never overlap.
   always_comb begin
      nxt = entries;
      for (int i = 0; i < N - 1; i++) begin
         if ((i % 2) == int'(pass_q[0])) begin
            if (mode_q ? (entries[i] < entries[i+1]) : (entries[i] > entries[i+1])) begin
               nxt[i]   = entries[i+1];
               nxt[i+1] = entries[i];
            end
         end
      end
   end

   // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (wr_acc && is_ctrl && wr_data[0]) state_d = SORT;
         SORT: if (last_pass) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge bus1_HCLK) begin
      if (bus1_HRESET) begin
         state_q                     <= IDLE;
         pass_q                      <= '0;
         mode_q                      <= 1'b0;
         done_q                      <= 1'b0;
         sortn_SA_bus1_CBM_read_data <= '0;
         out_sorted                  <= '0;
         sort_done                   <= 1'b0;
         // NOTE: the entry array is reset explicitly; it is flops, not a RAM, and a reset mid-sort must clear it.
         for (int i = 0; i < N; i++) entries[i] <= '0;
      end else begin
         state_q   <= state_d;
         sort_done <= 1'b0;
         if (rd_acc) sortn_SA_bus1_CBM_read_data <= rd_val;
         if (state_q == IDLE) begin
            if (wr_acc && is_entry) entries[idx] <= wr_data[W-1:0];
            if (wr_acc && is_ctrl) begin
               mode_q <= wr_data[1];
               if (wr_data[0]) begin
                  pass_q <= '0;
                  done_q <= 1'b0;
               end
            end
         end else begin
            entries <= nxt;
            pass_q  <= pass_q + PW'(1);
            if (last_pass) begin
               out_sorted <= nxt[0];
               done_q     <= 1'b1;
               sort_done  <= 1'b1;
            end
         end
      end
   end

endmodule
